// File: rtl/conf_int_mac_pkg.sv
// ----------------------------------------------------------------------------
// conf_int_mac_pkg
// Shared definitions for the configurable integer MAC and its inverse.
//   state_t     : FSM state encoding of the iterative inverse (IDLE/DIV/DONE)
//   OP_BW_DEF   : default operator width shared by the MAC and its inverse
//   DPW_DEF     : default datapath width shared by the MAC and its inverse
//   CNT_W       : iteration counter width at the default operator width
//   cnt_width() : iteration counter width for any operator width (>= 1 bit)
// ----------------------------------------------------------------------------
package conf_int_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OP_BW_DEF = 16;
  localparam int DPW_DEF   = 16;
  localparam int CNT_W     = $clog2(OP_BW_DEF);

  // A one-bit operator still needs a one-bit counter, so clamp at 1.
  function automatic int cnt_width(input int op_bw);
    if (op_bw > 1) begin
      return $clog2(op_bw);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/conf_int_div_step.sv
// ----------------------------------------------------------------------------
// conf_int_div_step
// One combinational iteration of an unsigned restoring divider.
//   rem_in       in  W  partial remainder from the previous iteration (< divisor)
//   dividend_bit in  1  next dividend bit, shifted into the remainder LSB
//   divisor      in  W  divisor
//   rem_out      out W  partial remainder after this iteration
//   q_bit        out 1  quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module conf_int_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  // The shifted remainder can reach 2*divisor-1, so the trial needs one extra bit.
  logic [W:0] trial_s;

  // Shift-in, compare, and conditionally subtract.
  always_comb begin
    trial_s = {rem_in, dividend_bit};
    if (trial_s >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      // The true difference is below the divisor, so the low W bits are exact.
      rem_out = trial_s[W-1:0] - divisor;
    end else begin
      q_bit   = 1'b0;
      rem_out = trial_s[W-1:0];
    end
  end

endmodule

// File: rtl/conf_int_mac_inv__seq.sv
// ----------------------------------------------------------------------------
// conf_int_mac_inv__seq
// Inverse of the configurable integer MAC d = a*b + c: recovers a = (d-c)/b and
// the remainder with a one-bit-per-cycle restoring divider.
//   clk          in   1    clock, rising edge
//   rst          in   1    synchronous active-low reset
//   in_valid     in   1    d_in/b_in/c_in valid
//   in_ready     out  1    operand set can be accepted (IDLE only)
//   d_in         in   DPW  MAC result
//   b_in         in   DPW  divisor
//   c_in         in   DPW  addend
//   out_valid    out  1    a_out/rem_out/div_by_zero valid
//   out_ready    in   1    downstream accepts the result
//   a_out        out  DPW  quotient (d-c)/b
//   rem_out      out  DPW  remainder (d-c)%b
//   div_by_zero  out  1    masked divisor was zero
// ----------------------------------------------------------------------------
module conf_int_mac_inv__seq
  import conf_int_mac_pkg::*;
#(
  parameter int OP_BITWIDTH        = OP_BW_DEF,
  parameter int DATA_PATH_BITWIDTH = DPW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] d_in,
  input  logic [DATA_PATH_BITWIDTH-1:0] b_in,
  input  logic [DATA_PATH_BITWIDTH-1:0] c_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] a_out,
  output logic [DATA_PATH_BITWIDTH-1:0] rem_out,
  output logic                          div_by_zero
);

  localparam int OPW = OP_BITWIDTH;
  localparam int DPW = DATA_PATH_BITWIDTH;
  localparam int CW  = cnt_width(OP_BITWIDTH);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  // Holds the dividend; quotient bits shift into the LSB as dividend bits leave the MSB.
  logic [OPW-1:0]  dq_r;
  logic [OPW-1:0]  divisor_r;
  logic [OPW-1:0]  rem_r;

  logic [OPW-1:0]  diff_s;
  logic [OPW-1:0]  step_rem_s;
  logic            step_q_s;
  logic [OPW-1:0]  quot_s;
  logic            accept_s;
  logic            last_iter_s;
  logic            release_s;

  logic            in_ready_r;
  logic            out_valid_r;
  logic            in_ready_nxt_s;
  logic            out_valid_nxt_s;
  logic [DPW-1:0]  a_out_r;
  logic [DPW-1:0]  rem_out_r;
  logic            div_by_zero_r;

  // Modular subtraction at operator width matches the MAC's truncation.
  assign diff_s      = d_in[OPW-1:0] - c_in[OPW-1:0];
  assign accept_s    = in_valid && in_ready_r;
  assign last_iter_s = (state_r == DIV) && (cnt_r == '0);
  assign release_s   = out_valid_r && out_ready;
  assign quot_s      = (dq_r << 1) | OPW'(step_q_s);

  conf_int_div_step #(
    .W (OPW)
  ) u_step (
    .rem_in       (rem_r),
    .dividend_bit (dq_r[OPW-1]),
    .divisor      (divisor_r),
    .rem_out      (step_rem_s),
    .q_bit        (step_q_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DIV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == '0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      DONE: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the flags can be registered.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    in_ready_nxt_s  = 1'b1;
      DONE:    out_valid_nxt_s = 1'b1;
      default: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Divider datapath: operand latch on accept, one iteration per DIV cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r     <= '0;
      dq_r      <= '0;
      divisor_r <= '0;
      rem_r     <= '0;
    end else if (accept_s) begin
      cnt_r     <= CW'(OPW - 1);
      dq_r      <= diff_s;
      divisor_r <= b_in[OPW-1:0];
      rem_r     <= '0;
    end else if (state_r == DIV) begin
      cnt_r     <= cnt_r - CW'(1);
      dq_r      <= quot_s;
      rem_r     <= step_rem_s;
    end else begin
      cnt_r     <= cnt_r;
      dq_r      <= dq_r;
      divisor_r <= divisor_r;
      rem_r     <= rem_r;
    end
  end

  // Result registers: written only on the final iteration, so they hold through DONE.
  // With a zero divisor every step subtracts nothing, which naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_out_r       <= '0;
      rem_out_r     <= '0;
      div_by_zero_r <= 1'b0;
    end else if (last_iter_s) begin
      a_out_r       <= DPW'(quot_s);
      rem_out_r     <= DPW'(step_rem_s);
      div_by_zero_r <= (divisor_r == '0);
    end else begin
      a_out_r       <= a_out_r;
      rem_out_r     <= rem_out_r;
      div_by_zero_r <= div_by_zero_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign a_out       = a_out_r;
  assign rem_out     = rem_out_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_conf_int_mac_inv__seq.sv
// ----------------------------------------------------------------------------
// tb_conf_int_mac_inv__seq
// Self-checking bench for the MAC inverse: directed cases, backpressure, reset
// during a divide, back-to-back throughput, random division and MAC loopback,
// all against a plain-arithmetic reference (quotient = diff / b).
// ----------------------------------------------------------------------------
module tb_conf_int_mac_inv__seq;

  localparam int OPW = 16;
  localparam int DPW = 16;
  localparam int LAT = OPW;
  localparam int PERIOD_CYC = OPW + 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DPW-1:0] d_in;
  logic [DPW-1:0] b_in;
  logic [DPW-1:0] c_in;
  logic           out_valid;
  logic           out_ready;
  logic [DPW-1:0] a_out;
  logic [DPW-1:0] rem_out;
  logic           div_by_zero;

  int pass_cnt;
  int tot_cnt;
  int cyc;
  int hs_cyc;

  conf_int_mac_inv__seq #(
    .OP_BITWIDTH        (OPW),
    .DATA_PATH_BITWIDTH (DPW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .d_in        (d_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_out       (a_out),
    .rem_out     (rem_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: unsigned (d - c) mod 2^OPW divided by b; b == 0 gives all ones / diff.
  function automatic void ref_div(input logic [15:0] d, input logic [15:0] b,
                                  input logic [15:0] c, output logic [15:0] q,
                                  output logic [15:0] r, output logic dz);
    int unsigned diff;
    diff = (int'(d) - int'(c) + 65536) % 65536;
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      r  = diff[15:0];
      dz = 1'b1;
    end else begin
      q  = 16'(diff / int'(b));
      r  = 16'(diff % int'(b));
      dz = 1'b0;
    end
  endfunction

  // Runs one operation; lat is the cycle count from handshake to out_valid, -1 if never accepted.
  task automatic do_op(input logic [15:0] d, input logic [15:0] b, input logic [15:0] c,
                       input bit release_out, output logic [15:0] a_o,
                       output logic [15:0] r_o, output logic dz_o, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      lat = -1; a_o = 16'hxxxx; r_o = 16'hxxxx; dz_o = 1'bx;
      return;
    end
    d_in = d; b_in = b; c_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    in_valid = 1'b0;
    // Scramble the inputs so any use of unlatched operands shows up.
    d_in = 16'($urandom); b_in = 16'($urandom); c_in = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    a_o = a_out; r_o = rem_out; dz_o = div_by_zero;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    d_in = 16'd0; b_in = 16'd0; c_in = 16'd0;
    @(posedge clk); @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    tot_cnt++; if (a_out !== 16'd0) $display("FAIL reset_a_out got=%h exp=0", a_out); else pass_cnt++;
    tot_cnt++; if (rem_out !== 16'd0) $display("FAIL reset_rem_out got=%h exp=0", rem_out); else pass_cnt++;
    tot_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] dd[3], bb[3], cc[3], qa[3], qr[3];
    logic        qz[3];
    logic [15:0] a_o, r_o;
    logic        dz_o;
    int          lat;
    dd = '{16'd100, 16'd3, 16'd50};
    bb = '{16'd8,   16'd2, 16'd0};
    cc = '{16'd4,   16'd5, 16'd7};
    qa = '{16'd12,  16'h7FFF, 16'hFFFF};
    qr = '{16'd0,   16'd0, 16'd43};
    qz = '{1'b0,    1'b0,  1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(dd[i], bb[i], cc[i], 1'b1, a_o, r_o, dz_o, lat);
      tot_cnt++; if (lat !== LAT) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); else pass_cnt++;
      tot_cnt++; if (a_o !== qa[i]) $display("FAIL dir%0d_a_out got=%h exp=%h", i, a_o, qa[i]); else pass_cnt++;
      tot_cnt++; if (r_o !== qr[i]) $display("FAIL dir%0d_rem_out got=%h exp=%h", i, r_o, qr[i]); else pass_cnt++;
      tot_cnt++; if (dz_o !== qz[i]) $display("FAIL dir%0d_dbz got=%b exp=%b", i, dz_o, qz[i]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a_o, r_o, eq, er;
    logic        dz_o, ez;
    int          lat;
    ref_div(16'd1234, 16'd10, 16'd3, eq, er, ez);
    do_op(16'd1234, 16'd10, 16'd3, 1'b0, a_o, r_o, dz_o, lat);
    tot_cnt++; if (a_o !== eq || r_o !== er) $display("FAIL bp_result got=%h/%h exp=%h/%h", a_o, r_o, eq, er); else pass_cnt++;
    // New operands offered while stalled in DONE must be ignored.
    d_in = 16'd999; b_in = 16'd3; c_in = 16'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tot_cnt++;
      if ({out_valid, in_ready, a_out, rem_out} !== {1'b1, 1'b0, eq, er})
        $display("FAIL bp_hold%0d got=%b%b/%h/%h exp=10/%h/%h", i, out_valid, in_ready, a_out, rem_out, eq, er);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tot_cnt++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] a_o, r_o, eq, er;
    logic        dz_o, ez;
    int          lat;
    d_in = 16'd60000; b_in = 16'd7; c_in = 16'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    tot_cnt++; if ({a_out, rem_out, div_by_zero} !== 33'd0) $display("FAIL midrst_outputs got=%h/%h/%b exp=0", a_out, rem_out, div_by_zero); else pass_cnt++;
    ref_div(16'd777, 16'd5, 16'd2, eq, er, ez);
    do_op(16'd777, 16'd5, 16'd2, 1'b1, a_o, r_o, dz_o, lat);
    tot_cnt++; if (lat !== LAT) $display("FAIL midrst_next_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
    tot_cnt++;
    if ({a_o, r_o, dz_o} !== {eq, er, ez}) $display("FAIL midrst_next_result got=%h/%h/%b exp=%h/%h/%b", a_o, r_o, dz_o, eq, er, ez);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_o, r_o;
    logic        dz_o;
    int          lat, prev;
    do_op(16'd10, 16'd3, 16'd0, 1'b1, a_o, r_o, dz_o, lat);
    prev = hs_cyc;
    for (int i = 0; i < 4; i++) begin
      do_op(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, a_o, r_o, dz_o, lat);
      tot_cnt++;
      if (hs_cyc - prev !== PERIOD_CYC) $display("FAIL b2b_interval%0d got=%0d exp=%0d", i, hs_cyc - prev, PERIOD_CYC);
      else pass_cnt++;
      prev = hs_cyc;
    end
  endtask

  task automatic test_random_div();
    logic [15:0] d, b, c, a_o, r_o, eq, er;
    logic        dz_o, ez;
    int          lat;
    for (int i = 0; i < 200; i++) begin
      d = 16'($urandom);
      c = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      ref_div(d, b, c, eq, er, ez);
      do_op(d, b, c, 1'b1, a_o, r_o, dz_o, lat);
      tot_cnt++;
      if ({a_o, r_o, dz_o} !== {eq, er, ez} || lat !== LAT)
        $display("FAIL rand%0d d=%h b=%h c=%h got=%h/%h/%b lat=%0d exp=%h/%h/%b lat=%0d",
                 i, d, b, c, a_o, r_o, dz_o, lat, eq, er, ez, LAT);
      else pass_cnt++;
    end
  endtask

  task automatic test_loopback();
    int unsigned a, b, c, d;
    logic [15:0] a_o, r_o;
    logic        dz_o;
    int          lat;
    for (int i = 0; i < 1000; i++) begin
      b = $urandom_range(1, 65535);
      a = $urandom_range(0, 65535 / b);
      c = $urandom_range(0, 65535 - a * b);
      d = a * b + c;
      do_op(d[15:0], b[15:0], c[15:0], 1'b1, a_o, r_o, dz_o, lat);
      tot_cnt++;
      if (a_o !== a[15:0]) $display("FAIL loop%0d_a got=%h exp=%h (b=%h c=%h)", i, a_o, a[15:0], b[15:0], c[15:0]); else pass_cnt++;
      tot_cnt++;
      if (r_o !== 16'd0 || dz_o !== 1'b0) $display("FAIL loop%0d_rem got=%h/%b exp=0/0", i, r_o, dz_o); else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    cyc      = 0;
    hs_cyc   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_div();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
